// File: rtl/counter_pkg.sv
// Shared definitions for the edge accountant: default counter width, snapshot FSM
// encoding and the all-ones reference constant.
package counter_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned ONES_W    = 64;

  localparam logic [ONES_W-1:0] ALL_ONES = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } snap_st_e;

endpackage

// File: rtl/counter_sat_cnt.sv
// One event counter with clear, clear-and-load-one, and optional saturation at all-ones.
module counter_sat_cnt
  import counter_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic         ld1,
  input  logic         sat_en,
  output logic [W-1:0] cnt,
  output logic         hit_max
);

  assign hit_max = (cnt == ALL_ONES[W-1:0]);

  // Clear takes priority; ld1 lets an edge in the clearing cycle survive as a count of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= ld1 ? W'(1) : W'(0);
    end else if (inc && !(hit_max && sat_en)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/counter_edge_rx.sv
// Receive-side edge accountant: counts rising, falling and one-cycle-pulse events on the
// synchronized level and offers a frozen snapshot over a valid/ready handshake.
module counter_edge_rx
  import counter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter bit          SAT_EN      = 1'b1,
  parameter bit          CLR_ON_SNAP = 1'b0
) (
  input  logic             i_clk_dout,
  input  logic             i_rst_dout,
  input  logic             i_syn_din,
  input  logic             i_cnt_en,
  input  logic             i_clr,
  input  logic             i_snap_req,
  input  logic             i_snap_rdy,
  output logic             o_snap_vld,
  output logic [CNT_W-1:0] o_snap_pose,
  output logic [CNT_W-1:0] o_snap_nege,
  output logic [CNT_W-1:0] o_snap_short,
  output logic [CNT_W-1:0] o_pose_cnt,
  output logic [CNT_W-1:0] o_nege_cnt,
  output logic [CNT_W-1:0] o_short_cnt,
  output logic             o_ovf
);

  logic     r_d1, r_d2;
  logic     rise, fall, short_pulse;
  logic     inc_pose, inc_nege, inc_short;
  logic     max_pose, max_nege, max_short;
  logic     cnt_clr, ovf_hit;
  logic     capture_c;
  snap_st_e state, state_nxt;

  assign rise        = i_syn_din & ~r_d1;
  assign fall        = ~i_syn_din & r_d1;
  assign short_pulse = fall & r_d1 & ~r_d2;

  assign inc_pose  = rise & i_cnt_en;
  assign inc_nege  = fall & i_cnt_en;
  assign inc_short = short_pulse & i_cnt_en;

  // An external clear discards same-cycle edges; a snapshot clear keeps them as a count of one.
  assign cnt_clr = i_clr | (capture_c & CLR_ON_SNAP);
  assign ovf_hit = (inc_pose & max_pose) | (inc_nege & max_nege) | (inc_short & max_short);

  always_comb begin
    state_nxt = state;
    capture_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_snap_req) begin
          capture_c = 1'b1;
          state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        if (i_snap_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_dout) begin
    if (i_rst_dout) begin
      state        <= ST_IDLE;
      r_d1         <= 1'b0;
      r_d2         <= 1'b0;
      o_ovf        <= 1'b0;
      o_snap_pose  <= '0;
      o_snap_nege  <= '0;
      o_snap_short <= '0;
    end else begin
      state <= state_nxt;
      r_d1  <= i_syn_din;
      r_d2  <= r_d1;
      if (cnt_clr)      o_ovf <= 1'b0;
      else if (ovf_hit) o_ovf <= 1'b1;
      if (capture_c) begin
        o_snap_pose  <= o_pose_cnt;
        o_snap_nege  <= o_nege_cnt;
        o_snap_short <= o_short_cnt;
      end
    end
  end

  assign o_snap_vld = (state == ST_VALID);

  counter_sat_cnt #(.W(CNT_W)) u_pose (
    .clk(i_clk_dout), .rst(i_rst_dout), .inc(inc_pose), .clr(cnt_clr),
    .ld1(inc_pose & ~i_clr), .sat_en(SAT_EN), .cnt(o_pose_cnt), .hit_max(max_pose)
  );

  counter_sat_cnt #(.W(CNT_W)) u_nege (
    .clk(i_clk_dout), .rst(i_rst_dout), .inc(inc_nege), .clr(cnt_clr),
    .ld1(inc_nege & ~i_clr), .sat_en(SAT_EN), .cnt(o_nege_cnt), .hit_max(max_nege)
  );

  counter_sat_cnt #(.W(CNT_W)) u_short (
    .clk(i_clk_dout), .rst(i_rst_dout), .inc(inc_short), .clr(cnt_clr),
    .ld1(inc_short & ~i_clr), .sat_en(SAT_EN), .cnt(o_short_cnt), .hit_max(max_short)
  );

endmodule

// File: tb/tb_counter_edge_rx.sv
// Directed bench for counter_edge_rx: a saturating and a wrapping 4-bit instance plus a
// 16-bit clear-on-snapshot instance, all driven from the same stimulus.
module tb_counter_edge_rx;

  logic clk, rst, syn, en, clr, req, rdy;

  logic       a_vld, a_ovf;
  logic [3:0] a_spose, a_snege, a_sshort, a_pose, a_nege, a_short;
  logic       b_vld, b_ovf;
  logic [3:0] b_spose, b_snege, b_sshort, b_pose, b_nege, b_short;
  logic        c_vld, c_ovf;
  logic [15:0] c_spose, c_snege, c_sshort, c_pose, c_nege, c_short;

  int n_vec = 0;
  int n_bad = 0;

  counter_edge_rx #(.CNT_W(4), .SAT_EN(1'b1), .CLR_ON_SNAP(1'b0)) dut_a (
    .i_clk_dout(clk), .i_rst_dout(rst), .i_syn_din(syn), .i_cnt_en(en), .i_clr(clr),
    .i_snap_req(req), .i_snap_rdy(rdy), .o_snap_vld(a_vld), .o_snap_pose(a_spose),
    .o_snap_nege(a_snege), .o_snap_short(a_sshort), .o_pose_cnt(a_pose),
    .o_nege_cnt(a_nege), .o_short_cnt(a_short), .o_ovf(a_ovf)
  );

  counter_edge_rx #(.CNT_W(4), .SAT_EN(1'b0), .CLR_ON_SNAP(1'b0)) dut_b (
    .i_clk_dout(clk), .i_rst_dout(rst), .i_syn_din(syn), .i_cnt_en(en), .i_clr(clr),
    .i_snap_req(req), .i_snap_rdy(rdy), .o_snap_vld(b_vld), .o_snap_pose(b_spose),
    .o_snap_nege(b_snege), .o_snap_short(b_sshort), .o_pose_cnt(b_pose),
    .o_nege_cnt(b_nege), .o_short_cnt(b_short), .o_ovf(b_ovf)
  );

  counter_edge_rx #(.CNT_W(16), .SAT_EN(1'b1), .CLR_ON_SNAP(1'b1)) dut_c (
    .i_clk_dout(clk), .i_rst_dout(rst), .i_syn_din(syn), .i_cnt_en(en), .i_clr(clr),
    .i_snap_req(req), .i_snap_rdy(rdy), .o_snap_vld(c_vld), .o_snap_pose(c_spose),
    .o_snap_nege(c_snege), .o_snap_short(c_sshort), .o_pose_cnt(c_pose),
    .o_nege_cnt(c_nege), .o_short_cnt(c_short), .o_ovf(c_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       syn;
    logic       en;
    logic       clr;
    logic [3:0] pose;
    logic [3:0] nege;
    logic [3:0] shrt;
    logic       ovf;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; syn = 1'b0; en = 1'b1; clr = 1'b0; req = 1'b0; rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) begin
      syn = 1'b1; tick();
      syn = 1'b0; tick();
    end
  endtask

  initial begin
    // syn en clr | pose nege short ovf
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 4'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 4'd0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 4'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'd2, 4'd2, 4'd1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'd2, 4'd2, 4'd1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd2, 4'd2, 4'd1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd2, 4'd2, 4'd1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 4'd2, 4'd2, 4'd1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 4'd0, 1'b0};

    do_reset();
    check("rst_pose",  32'(a_pose),  32'd0);
    check("rst_nege",  32'(a_nege),  32'd0);
    check("rst_short", 32'(a_short), 32'd0);
    check("rst_ovf",   32'(a_ovf),   32'd0);
    check("rst_vld",   32'(a_vld),   32'd0);
    check("rst_spose", 32'(a_spose), 32'd0);

    for (int i = 0; i < 16; i++) begin
      syn = vecs[i].syn; en = vecs[i].en; clr = vecs[i].clr;
      tick();
      check($sformatf("v%0d_pose", i),  32'(a_pose),  32'(vecs[i].pose));
      check($sformatf("v%0d_nege", i),  32'(a_nege),  32'(vecs[i].nege));
      check($sformatf("v%0d_short", i), 32'(a_short), 32'(vecs[i].shrt));
      check($sformatf("v%0d_ovf", i),   32'(a_ovf),   32'(vecs[i].ovf));
    end
    clr = 1'b0; en = 1'b1;

    // Saturate vs wrap at 4 bits
    do_reset();
    pulses(15);
    check("sat15_pose",  32'(a_pose),  32'd15);
    check("sat15_short", 32'(a_short), 32'd15);
    check("sat15_ovf",   32'(a_ovf),   32'd0);
    check("wrap15_pose", 32'(b_pose),  32'd15);
    syn = 1'b1; tick();
    check("sat16_pose",  32'(a_pose),  32'd15);
    check("sat16_ovf",   32'(a_ovf),   32'd1);
    check("wrap16_pose", 32'(b_pose),  32'd0);
    check("wrap16_ovf",  32'(b_ovf),   32'd1);
    syn = 1'b0; tick();
    check("sat16_nege",  32'(a_nege),  32'd15);
    check("wrap16_nege", 32'(b_nege),  32'd0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_ovf_a",   32'(a_ovf),   32'd0);
    check("clr_ovf_b",   32'(b_ovf),   32'd0);

    // Snapshot held while consumer stalls
    do_reset();
    pulses(3);
    req = 1'b1; tick(); req = 1'b0;
    check("snap_vld",  32'(a_vld),   32'd1);
    check("snap_pose", 32'(a_spose), 32'd3);
    for (int k = 0; k < 4; k++) begin
      syn = (k % 2 == 0);
      req = (k == 0);
      tick();
      check($sformatf("stall%0d_vld", k),  32'(a_vld),   32'd1);
      check($sformatf("stall%0d_pose", k), 32'(a_spose), 32'd3);
    end
    req = 1'b0;
    check("stall_live", 32'(a_pose), 32'd5);
    rdy = 1'b1; req = 1'b1; tick();
    check("rdy_vld",   32'(a_vld),   32'd0);
    rdy = 1'b0; tick();
    check("b2b_vld",   32'(a_vld),   32'd1);
    check("b2b_pose",  32'(a_spose), 32'd5);
    req = 1'b0; rdy = 1'b1; tick(); rdy = 1'b0;
    check("b2b_drop",  32'(a_vld),   32'd0);

    // Capture coincident with a rise, clear-on-snapshot instance
    do_reset();
    pulses(7);
    syn = 1'b1; req = 1'b1; tick(); req = 1'b0;
    check("cos_spose",  32'(c_spose), 32'd7);
    check("cos_pose",   32'(c_pose),  32'd1);
    check("cos_nege",   32'(c_nege),  32'd0);
    check("cos_short",  32'(c_short), 32'd0);
    check("cos_sshort", 32'(c_sshort), 32'd7);
    check("cos_vld",    32'(c_vld),   32'd1);
    check("nocos_spose", 32'(a_spose), 32'd7);
    check("nocos_pose",  32'(a_pose),  32'd8);

    // Clear during VALID leaves the snapshot alone
    clr = 1'b1; tick(); clr = 1'b0;
    check("vclr_pose",  32'(a_pose),  32'd0);
    check("vclr_spose", 32'(a_spose), 32'd7);
    check("vclr_vld",   32'(a_vld),   32'd1);

    // Reset during VALID drops the snapshot
    rst = 1'b1; tick(); rst = 1'b0;
    check("rv_vld_a",   32'(a_vld),   32'd0);
    check("rv_vld_c",   32'(c_vld),   32'd0);
    check("rv_pose",    32'(c_pose),  32'd0);
    check("rv_spose",   32'(a_spose), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
